// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package regfile_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;

  typedef enum logic {IDLE, OWN_B} wr_arb_state_t;
  typedef enum logic {REQ_A, REQ_B} wr_req_id_t;
endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that did not win last time is granted.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req_i,
  input  wr_req_id_t last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = (last_i == REQ_B) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the RegFile write port between requester A (ALU) and B (load/restore),
// round-robin with a bounded burst lock for B, registered write outputs.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 hold_i,
  input  logic                 a_valid_i,
  input  logic [ADDR_W-1:0]    a_addr_i,
  input  logic [DATA_W-1:0]    a_data_i,
  output logic                 a_ready_o,
  input  logic                 b_valid_i,
  input  logic                 b_lock_i,
  input  logic [ADDR_W-1:0]    b_addr_i,
  input  logic [DATA_W-1:0]    b_data_i,
  output logic                 b_ready_o,
  output logic                 write_en_o,
  output logic [ADDR_W-1:0]    waddr_o,
  output logic [DATA_W-1:0]    data_in_o,
  output logic [(1<<ADDR_W)-1:0] busy_o
);

  // state | meaning
  // IDLE  | no lock held; round-robin between A and B
  // OWN_B | B holds a burst lock; A only wins once the burst limit is hit
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam int NREG = 1 << ADDR_W;

  wr_arb_state_t     state_q, state_d;
  wr_req_id_t        last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_en_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        rr_gnt;
  logic              gnt_a, gnt_b;

  rr_arb2 u_rr (
    .req_i  ({b_valid_i, a_valid_i}),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset_ni && !hold_i) begin
      if (state_q == OWN_B) begin
        if (b_valid_i && (cnt_q < CNT_MAX || !a_valid_i)) gnt_b = 1'b1;
        else                                              gnt_a = a_valid_i;
      end else begin
        gnt_a = rr_gnt[0];
        gnt_b = rr_gnt[1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      if (gnt_a) last_d = REQ_A;
      if (gnt_b) last_d = REQ_B;
      // Any cycle without a locked B beat ends the burst.
      if (gnt_b && b_lock_i) begin
        state_d = OWN_B;
        if (state_q == IDLE)      cnt_d = CNT_W'(1);
        else if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      last_q     <= REQ_B;
      cnt_q      <= '0;
      write_en_q <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      write_en_q <= gnt_a | gnt_b;
      if (gnt_a) begin
        waddr_q <= a_addr_i;
        data_q  <= a_data_i;
      end else if (gnt_b) begin
        waddr_q <= b_addr_i;
        data_q  <= b_data_i;
      end
    end
  end

  assign a_ready_o  = gnt_a;
  assign b_ready_o  = gnt_b;
  assign write_en_o = write_en_q;
  assign waddr_o    = waddr_q;
  assign data_in_o  = data_q;
  assign busy_o     = {{(NREG-1){1'b0}}, write_en_q} << waddr_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized + directed bench for regfile_wr_arbiter with a behavioural RegFile behind it.
`timescale 1ps/1ps
module tb_regfile_wr_arbiter;
  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset_n, hold;
  logic       a_valid, b_valid, b_lock;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready_o, b_ready_o, write_en_o;
  logic [2:0] waddr_o;
  logic [7:0] data_in_o;
  logic [7:0] busy_o;

  logic [7:0] rf [8];
  logic [7:0] ref_rf [8];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who won last, whether B holds a lock and for how many beats
  int         m_last;
  bit         m_lock;
  int         m_beats;
  bit         m_we;
  logic [2:0] m_waddr;
  logic [7:0] m_data;
  int         last_g, obs_g;

  regfile_wr_arbiter #(.ADDR_W(3), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk_i(clk), .reset_ni(reset_n), .hold_i(hold),
    .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid), .b_lock_i(b_lock), .b_addr_i(b_addr), .b_data_i(b_data),
    .b_ready_o(b_ready_o), .write_en_o(write_en_o), .waddr_o(waddr_o),
    .data_in_o(data_in_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write_en_o) rf[waddr_o] <= data_in_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0 = nobody, 1 = A, 2 = B
  function automatic int model_grant();
    if (!reset_n || hold) return 0;
    if (m_lock) begin
      if (b_valid && (m_beats < MAXB || !a_valid)) return 2;
      return a_valid ? 1 : 0;
    end
    if (a_valid && b_valid) return (m_last == 2) ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic model_update(input int g);
    if (m_we) ref_rf[m_waddr] = m_data;
    if (!reset_n) begin
      m_we = 0; m_waddr = '0; m_data = '0; m_lock = 0; m_beats = 0; m_last = 2;
    end else if (hold) begin
      m_we = 0;
    end else begin
      m_we = (g != 0);
      if (g == 1) begin m_waddr = a_addr; m_data = a_data; m_last = 1; end
      if (g == 2) begin m_waddr = b_addr; m_data = b_data; m_last = 2; end
      if (g == 2 && b_lock) begin
        if (m_lock) m_beats = (m_beats < MAXB) ? m_beats + 1 : MAXB;
        else begin m_lock = 1; m_beats = 1; end
      end else begin
        m_lock = 0; m_beats = 0;
      end
    end
  endtask

  task automatic cycle();
    int g;
    #1;
    g = model_grant();
    obs_g = a_ready_o ? 1 : (b_ready_o ? 2 : 0);
    chk("a_ready", a_ready_o, g == 1);
    chk("b_ready", b_ready_o, g == 2);
    last_g = g;
    @(posedge clk);
    model_update(g);
    @(negedge clk);
    chk("write_en", write_en_o, m_we);
    chk("waddr", waddr_o, m_waddr);
    chk("data_in", data_in_o, m_data);
    chk("busy", busy_o, m_we ? (32'd1 << m_waddr) : 32'd0);
  endtask

  task automatic rf_check();
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), rf[i], ref_rf[i]);
  endtask

  initial begin
    logic [2:0] t4_addr [6];
    logic [7:0] t4_data [6];
    int t4_exp [6];
    int bi;
    t4_addr = '{3'd1, 3'd7, 3'd4, 3'd5, 3'd6, 3'd6};
    t4_data = '{8'd8, 8'd15, 8'd1, 8'd2, 8'd3, 8'd3};
    t4_exp  = '{2, 2, 2, 2, 1, 2};
    for (int i = 0; i < 8; i++) begin rf[i] = '0; ref_rf[i] = '0; end
    m_last = 2; m_lock = 0; m_beats = 0; m_we = 0; m_waddr = '0; m_data = '0; last_g = 0;

    // 1: reset with both valid, then first tie goes to A
    reset_n = 0; hold = 0; b_lock = 0;
    a_valid = 1; a_addr = 3'd0; a_data = 8'h11;
    b_valid = 1; b_addr = 3'd1; b_data = 8'h22;
    @(negedge clk);
    cycle(); chk("t1_rst_ready", {a_ready_o, b_ready_o}, 2'b00);
    cycle(); chk("t1_rst_we", write_en_o, 1'b0);
    reset_n = 1;
    cycle(); chk("t1_first_tie", obs_g, 1);
    a_valid = 0;
    cycle(); chk("t1_b_next", obs_g, 2);
    b_valid = 0;
    cycle();

    // 2: single A write
    a_valid = 1; a_addr = 3'd2; a_data = 8'd22;
    cycle(); chk("t2_a_ready", obs_g, 1);
    a_valid = 0;
    chk("t2_we", write_en_o, 1'b1);
    chk("t2_waddr", waddr_o, 3'd2);
    chk("t2_data", data_in_o, 8'd22);
    chk("t2_busy", busy_o, 8'h04);
    cycle(); cycle();
    chk("t2_rf2", rf[2], 8'd22);

    // 3: same register from both; B-only write first so the next tie favours A
    b_valid = 1; b_addr = 3'd5; b_data = 8'h55;
    cycle();
    a_valid = 1; a_addr = 3'd3; a_data = 8'd16;
    b_addr = 3'd3; b_data = 8'd9;
    for (int i = 0; i < 4; i++) begin
      cycle(); chk("t3_alt", obs_g, (i % 2 == 0) ? 1 : 2);
    end
    a_valid = 0; b_valid = 0;
    cycle(); cycle();
    chk("t3_rf3", rf[3], 8'd9);

    // 4: B burst against a persistent A request
    a_valid = 1; a_addr = 3'd0; a_data = 8'd5;
    cycle();
    b_valid = 1; b_lock = 1; bi = 0;
    for (int i = 0; i < 6; i++) begin
      b_addr = t4_addr[bi]; b_data = t4_data[bi];
      cycle(); chk($sformatf("t4_beat%0d", i), obs_g, t4_exp[i]);
      if (obs_g == 2 && bi < 5) bi++;
    end

    // 5: hold freezes the lock (count 1)
    b_addr = 3'd2; b_data = 8'h40; hold = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("t5_hold_none", obs_g, 0);
      chk("t5_hold_we", write_en_o, 1'b0);
    end
    hold = 0;
    cycle(); chk("t5_resume_b", obs_g, 2);

    // 6: reset at count 2 drops the lock
    b_addr = 3'd3; b_data = 8'h41; reset_n = 0;
    cycle(); chk("t6_we", write_en_o, 1'b0);
    reset_n = 1;
    cycle(); chk("t6_tie_a", obs_g, 1);
    cycle(); chk("t6_then_b", obs_g, 2);
    a_valid = 0; b_valid = 0; b_lock = 0;
    cycle(); cycle();
    chk("t4_rf7", rf[7], 8'd15);
    chk("t4_rf1", rf[1], 8'd8);
    rf_check();

    // random phase; requesters keep a pending write stable until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!(a_valid && last_g != 1)) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr = 3'($urandom); a_data = 8'($urandom);
      end
      if (!(b_valid && last_g != 2)) begin
        b_valid = ($urandom_range(0, 99) < 60);
        b_lock = ($urandom_range(0, 99) < 70);
        b_addr = 3'($urandom); b_data = 8'($urandom);
      end
      hold = ($urandom_range(0, 99) < 15);
      reset_n = ($urandom_range(0, 99) >= 2);
      cycle();
    end
    reset_n = 1; hold = 0; a_valid = 0; b_valid = 0;
    cycle(); cycle();
    rf_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
